perf_counter_reader: RTL and testbench

- CSR-side reader for the core's five 32-bit performance counters: cycle, instructions, stalls, branches, and branch mispredicts.
- Extends each counter to 64 bits by detecting wrap-around.
- Holds a freezable shadow bank of the extended values.
- Serves read requests addressed by RISC-V CSR number over a valid/ready request/response handshake.
- Sits between the performance counter bank and the CSR read path in EX.

---
 rtl/perf_counter_reader.sv | 156 +++++++++++++++
 tb/tb_perf_counter_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_reader.sv
// CSR reader for five perf counters, 64-bit extended by wrap detection, served from a freezable shadow bank.
// Response registered two cycles after the accepting cycle; holds rsp_* until rsp_ready, req_ready low while busy.
module perf_counter_reader #(
  parameter logic [11:0] CSR_LO_BASE = 12'hB00,
  parameter logic [11:0] CSR_HI_BASE = 12'hB80,
  parameter bit          USER_ALIAS  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cycle_count,
  input  logic [31:0] instruction_count,
  input  logic [31:0] stall_count,
  input  logic [31:0] branch_count,
  input  logic [31:0] branch_mispredicts,
  input  logic        counters_clear,
  input  logic        freeze,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);
  localparam int          NUM_CNT      = 5;
  localparam logic [11:0] USER_LO_BASE = 12'hC00;
  localparam logic [11:0] USER_HI_BASE = 12'hC80;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;
  state_t state, state_nxt;

  logic [31:0]        cnt    [NUM_CNT];
  logic [31:0]        prev   [NUM_CNT];
  logic [31:0]        upper  [NUM_CNT];
  logic [63:0]        ext    [NUM_CNT];
  logic [63:0]        shadow [NUM_CNT];
  logic [NUM_CNT-1:0] wrap;
  logic [11:0]        addr_q;

  assign cnt[0] = cycle_count;
  assign cnt[1] = instruction_count;
  assign cnt[2] = stall_count;
  assign cnt[3] = branch_count;
  assign cnt[4] = branch_mispredicts;

  // The wrap term is folded in combinationally so the wrap cycle already carries.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      wrap[i] = (prev[i] == 32'hFFFF_FFFF) && (cnt[i] == 32'd0) && !counters_clear;
      ext[i]  = {upper[i] + {31'd0, wrap[i]}, cnt[i]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        prev[i]   <= '0;
        upper[i]  <= '0;
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (counters_clear) begin
          prev[i]   <= '0;
          upper[i]  <= '0;
          shadow[i] <= '0;
        end else begin
          prev[i]  <= cnt[i];
          upper[i] <= ext[i][63:32];
          if (!freeze) shadow[i] <= ext[i];
        end
      end
    end
  end

  // Address decode against the latched CSR number; bases need not be 32-aligned.
  logic [11:0] lo_off, hi_off, ulo_off, uhi_off;
  logic        in_range, sel_hi, hit, lk_err;
  logic [4:0]  off;
  logic [63:0] sel;
  logic [31:0] lk_data;

  always_comb begin
    lo_off   = addr_q - CSR_LO_BASE;
    hi_off   = addr_q - CSR_HI_BASE;
    ulo_off  = addr_q - USER_LO_BASE;
    uhi_off  = addr_q - USER_HI_BASE;
    in_range = 1'b0;
    sel_hi   = 1'b0;
    off      = '0;
    if (lo_off < 12'd32) begin
      in_range = 1'b1;
      off      = lo_off[4:0];
    end else if (hi_off < 12'd32) begin
      in_range = 1'b1;
      sel_hi   = 1'b1;
      off      = hi_off[4:0];
    end else if (USER_ALIAS && (ulo_off < 12'd32)) begin
      in_range = 1'b1;
      off      = ulo_off[4:0];
    end else if (USER_ALIAS && (uhi_off < 12'd32)) begin
      in_range = 1'b1;
      sel_hi   = 1'b1;
      off      = uhi_off[4:0];
    end
    hit = in_range;
    sel = '0;
    case (off)
      5'd0:    sel = shadow[0];
      5'd2:    sel = shadow[1];
      5'd3:    sel = shadow[2];
      5'd4:    sel = shadow[3];
      5'd5:    sel = shadow[4];
      default: hit = 1'b0;
    endcase
    lk_err  = !hit;
    lk_data = !hit ? 32'd0 : (sel_hi ? sel[63:32] : sel[31:0]);
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = LOOKUP;
      end
      LOOKUP: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) addr_q <= req_addr;
      if (state == LOOKUP) begin
        rsp_data <= lk_data;
        rsp_err  <= lk_err;
      end else if (state == RESP && rsp_ready) begin
        rsp_data <= '0;
        rsp_err  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_perf_counter_reader.sv
// Directed bench for perf_counter_reader: reset, wrap extension, clear, freeze, decode and backpressure.
module tb_perf_counter_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cycle_count, instruction_count, stall_count, branch_count, branch_mispredicts;
  logic        counters_clear, freeze;
  logic        req_valid, req_ready;
  logic [11:0] req_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  perf_counter_reader dut (
    .clk               (clk),
    .reset             (reset),
    .cycle_count       (cycle_count),
    .instruction_count (instruction_count),
    .stall_count       (stall_count),
    .branch_count      (branch_count),
    .branch_mispredicts(branch_mispredicts),
    .counters_clear    (counters_clear),
    .freeze            (freeze),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .rsp_err           (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fixed-latency read: accept, LOOKUP, then sample the RESP cycle and release it.
  task automatic do_read(input logic [11:0] a, output logic v_lk, output logic v,
                         output logic [31:0] d, output logic e);
    req_addr  = a;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    v_lk      = rsp_valid;
    tick();
    v = rsp_valid;
    d = rsp_data;
    e = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic v_lk, v, e;
    logic [31:0] d;
    reset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_data !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    tick();
    reset = 1'b1;
    cycle_count = 32'h0000_1234;
    tick();
    req_addr  = 12'hB00;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_rsp_valid: got %b want 1", rsp_valid); end
    reset = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midresp_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midresp_req_ready: got %b want 1", req_ready); end
    tick();
    reset = 1'b1;
    tick();
    do_read(12'hB00, v_lk, v, d, e);
    n_checks++; if (v_lk !== 1'b0) begin n_fail++; $display("FAIL latency_lookup_valid: got %b want 0", v_lk); end
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL latency_resp_valid: got %b want 1", v); end
    n_checks++; if (d !== 32'h0000_1234) begin n_fail++; $display("FAIL post_reset_cycle: got %h want 00001234", d); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL post_reset_err: got %b want 0", e); end
  endtask

  task automatic test_wrap();
    logic v_lk, v, e;
    logic [31:0] d;
    cycle_count = 32'hFFFF_FFFE; tick();
    cycle_count = 32'hFFFF_FFFF; tick();
    cycle_count = 32'h0000_0000; tick();
    cycle_count = 32'h0000_0001; tick();
    do_read(12'hB80, v_lk, v, d, e);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL wrap_hi: got %h want 00000001", d); end
    do_read(12'hB00, v_lk, v, d, e);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL wrap_lo: got %h want 00000001", d); end
    // Freeze right after a second wrap: the shadow must already hold the carried upper half.
    cycle_count = 32'hFFFF_FFFF; tick();
    cycle_count = 32'h0000_0000; tick();
    freeze = 1'b1;
    cycle_count = 32'h0000_0005;
    do_read(12'hB80, v_lk, v, d, e);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL wrap_cycle_carry_hi: got %h want 00000002", d); end
    do_read(12'hB00, v_lk, v, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL wrap_cycle_carry_lo: got %h want 00000000", d); end
    freeze = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    logic v_lk, v, e;
    logic [31:0] d;
    stall_count = 32'd7;
    cycle_count = 32'hFFFF_FFFE; tick();
    cycle_count = 32'hFFFF_FFFF; tick();
    cycle_count = 32'h0000_0000; counters_clear = 1'b1; tick();
    counters_clear = 1'b0;
    cycle_count = 32'h0000_0001; tick();
    do_read(12'hB80, v_lk, v, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL clear_hi: got %h want 00000000", d); end
    do_read(12'hB03, v_lk, v, d, e);
    n_checks++; if (d !== 32'd7) begin n_fail++; $display("FAIL clear_stall: got %h want 00000007", d); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL clear_stall_err: got %b want 0", e); end
  endtask

  task automatic test_freeze();
    logic v_lk, v, e;
    logic [31:0] d;
    branch_count = 32'd100; tick();
    freeze = 1'b1;
    branch_count = 32'd200; tick(); tick();
    do_read(12'hB04, v_lk, v, d, e);
    n_checks++; if (d !== 32'd100) begin n_fail++; $display("FAIL freeze_hold: got %0d want 100", d); end
    freeze = 1'b0;
    do_read(12'hB04, v_lk, v, d, e);
    n_checks++; if (d !== 32'd200) begin n_fail++; $display("FAIL freeze_release: got %0d want 200", d); end
  endtask

  task automatic test_decode();
    logic v_lk, v, e;
    logic [31:0] d;
    instruction_count = 32'hDEAD_BEEF;
    branch_mispredicts = 32'h0000_0042;
    do_read(12'hB01, v_lk, v, d, e);
    n_checks++; if (v_lk !== 1'b0 || v !== 1'b1) begin n_fail++; $display("FAIL unmapped_b01_timing: got lk=%b resp=%b want 0/1", v_lk, v); end
    n_checks++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL unmapped_b01: got err=%b data=%h want 1/0", e, d); end
    do_read(12'h123, v_lk, v, d, e);
    n_checks++; if (v !== 1'b1 || e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL unmapped_123: got v=%b err=%b data=%h want 1/1/0", v, e, d); end
    do_read(12'hB06, v_lk, v, d, e);
    n_checks++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL unmapped_b06: got err=%b data=%h want 1/0", e, d); end
    do_read(12'hC02, v_lk, v, d, e);
    n_checks++; if (e !== 1'b0 || d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL alias_c02: got err=%b data=%h want 0/deadbeef", e, d); end
    do_read(12'hC82, v_lk, v, d, e);
    n_checks++; if (e !== 1'b0 || d !== 32'd0) begin n_fail++; $display("FAIL alias_c82: got err=%b data=%h want 0/0", e, d); end
    do_read(12'hB05, v_lk, v, d, e);
    n_checks++; if (e !== 1'b0 || d !== 32'h42) begin n_fail++; $display("FAIL mispredict_b05: got err=%b data=%h want 0/42", e, d); end
  endtask

  task automatic test_back_to_back();
    cycle_count = 32'h0000_ABCD;
    instruction_count = 32'h0000_5678;
    tick();
    req_addr  = 12'hB00;
    req_valid = 1'b1;
    tick();
    req_addr = 12'hC02;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_lookup_ready: got %b want 0", req_ready); end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== 32'h0000_ABCD) begin
        n_fail++; $display("FAIL b2b_hold_%0d: got v=%b rdy=%b data=%h want 1/0/0000abcd", i, rsp_valid, req_ready, rsp_data);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got rdy=%b v=%b data=%h err=%b want 1/0/0/0", req_ready, rsp_valid, rsp_data, rsp_err);
    end
    tick();
    req_valid = 1'b0;
    n_checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: got rdy=%b v=%b want 0/0", req_ready, rsp_valid); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_5678 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_rsp: got v=%b data=%h err=%b want 1/00005678/0", rsp_valid, rsp_data, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    cycle_count = '0; instruction_count = '0; stall_count = '0;
    branch_count = '0; branch_mispredicts = '0;
    counters_clear = 1'b0; freeze = 1'b0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    test_reset();
    test_wrap();
    test_clear();
    test_freeze();
    test_decode();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
